// File: rtl/game_flow_fsm.sv
// -----------------------------------------------------------------------------
// game_flow_fsm
//
// Top-level game-flow controller for the FPGA chess project. Sequences the
// TITLE -> PLAYER (timed splash) -> BOARD -> PLAYING -> GAME_OVER screens and
// owns turn tracking, the per-move clock with timeout, resignation and
// external end-of-game handling.
//
// Input protocol: enter/back are debounced levels and are edge-detected here;
// move_done/game_end are single-cycle pulses, only acted on in PLAYING. There
// is no back-pressure anywhere: every input is consumed in the cycle it is
// sampled.
//
// Parameters
//   CLK_FREQ_HZ    clk cycles per second (move-clock prescaler period)
//   SPLASH_SEC     seconds the PLAYER screen is held (>= 1)
//   TURN_TIME_SEC  per-move time limit in seconds, 0 disables the move clock
//   TW             width of time_left (derived)
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   enter, back         debounced key levels
//   move_done           pulse: current player committed a legal move
//   game_end            pulse: checkmate/stalemate detected
//   game_end_winner     qualifies game_end: 00 white, 01 black, 10 draw
//   state               0 TITLE, 1 PLAYER, 2 BOARD, 3 PLAYING, 4 GAME_OVER
//   state_entry         high for the first cycle in a new state
//   turn                0 white to move, 1 black to move
//   winner              00 white, 01 black, 10 draw, 11 none
//   end_reason          00 none, 01 external, 10 resign, 11 timeout
//   time_left           whole seconds remaining for the current move
// -----------------------------------------------------------------------------
module game_flow_fsm #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int SPLASH_SEC    = 2,
    parameter int TURN_TIME_SEC = 60,
    parameter int TW            = (TURN_TIME_SEC > 0) ? $clog2(TURN_TIME_SEC + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enter,
    input  logic          back,
    input  logic          move_done,
    input  logic          game_end,
    input  logic [1:0]    game_end_winner,
    output logic [2:0]    state,
    output logic          state_entry,
    output logic          turn,
    output logic [1:0]    winner,
    output logic [1:0]    end_reason,
    output logic [TW-1:0] time_left
);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_PLAYER    = 3'd1,
        S_BOARD     = 3'd2,
        S_PLAYING   = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int SPLASH_CYCLES = CLK_FREQ_HZ * SPLASH_SEC;
    localparam int SW            = (SPLASH_CYCLES > 1) ? $clog2(SPLASH_CYCLES) : 1;
    localparam int PW            = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam bit CLOCK_EN      = (TURN_TIME_SEC > 0);

    localparam logic [SW-1:0] SPLASH_LAST = SW'(SPLASH_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_FREQ_HZ - 1);
    localparam logic [TW-1:0] TIME_RELOAD = TW'(TURN_TIME_SEC);

    state_t        state_q;
    logic          enter_q;
    logic          back_q;
    logic [SW-1:0] splash_cnt;
    logic [PW-1:0] presc_cnt;

    logic enter_edge;
    logic back_edge;
    logic wrap;
    logic timeout;

    assign state = state_q;

    // Key history registers reset to 1 so a key held through reset is not
    // mistaken for a fresh press.
    assign enter_edge = enter & ~enter_q;
    assign back_edge  = back & ~back_q;

    // One-second tick of the move clock, and the tick that exhausts the turn.
    assign wrap    = CLOCK_EN && (presc_cnt == PRESC_LAST);
    assign timeout = wrap && (time_left == TW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_TITLE;
            state_entry <= 1'b0;
            turn        <= 1'b0;
            winner      <= 2'b11;
            end_reason  <= 2'b00;
            time_left   <= '0;
            enter_q     <= 1'b1;
            back_q      <= 1'b1;
            splash_cnt  <= '0;
            presc_cnt   <= '0;
        end else begin
            enter_q     <= enter;
            back_q      <= back;
            state_entry <= 1'b0;
            // Both counters sit at zero unless their state advances them.
            splash_cnt  <= '0;
            presc_cnt   <= '0;

            case (state_q)
                S_TITLE: begin
                    if (enter_edge) begin
                        state_q     <= S_PLAYER;
                        state_entry <= 1'b1;
                    end
                end

                S_PLAYER: begin
                    if (back_edge) begin
                        state_q     <= S_TITLE;
                        state_entry <= 1'b1;
                    end else if (splash_cnt == SPLASH_LAST) begin
                        state_q     <= S_BOARD;
                        state_entry <= 1'b1;
                    end else begin
                        splash_cnt <= splash_cnt + SW'(1);
                    end
                end

                S_BOARD: begin
                    if (back_edge) begin
                        state_q     <= S_TITLE;
                        state_entry <= 1'b1;
                    end else if (enter_edge) begin
                        state_q     <= S_PLAYING;
                        state_entry <= 1'b1;
                        turn        <= 1'b0;
                        time_left   <= TIME_RELOAD;
                        winner      <= 2'b11;
                        end_reason  <= 2'b00;
                    end
                end

                S_PLAYING: begin
                    if (game_end) begin
                        state_q     <= S_GAME_OVER;
                        state_entry <= 1'b1;
                        // 11 is not a legal result; report it as a draw.
                        winner      <= (game_end_winner == 2'b11) ? 2'b10 : game_end_winner;
                        end_reason  <= 2'b01;
                    end else if (back_edge) begin
                        state_q     <= S_GAME_OVER;
                        state_entry <= 1'b1;
                        winner      <= {1'b0, ~turn};
                        end_reason  <= 2'b10;
                    end else if (timeout) begin
                        // A move committed on this same cycle is late.
                        state_q     <= S_GAME_OVER;
                        state_entry <= 1'b1;
                        winner      <= {1'b0, ~turn};
                        end_reason  <= 2'b11;
                        time_left   <= '0;
                    end else if (move_done) begin
                        turn      <= ~turn;
                        time_left <= TIME_RELOAD;
                    end else if (CLOCK_EN) begin
                        if (wrap) begin
                            time_left <= time_left - TW'(1);
                        end else begin
                            presc_cnt <= presc_cnt + PW'(1);
                        end
                    end
                end

                S_GAME_OVER: begin
                    if (enter_edge) begin
                        state_q     <= S_TITLE;
                        state_entry <= 1'b1;
                        winner      <= 2'b11;
                        end_reason  <= 2'b00;
                        turn        <= 1'b0;
                        time_left   <= '0;
                    end
                end

                default: begin
                    state_q     <= S_TITLE;
                    state_entry <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/game_flow_fsm.md
# game_flow_fsm

Parametrised top-level game-flow controller for FPGA chess, sequencing title, player, board, playing and game-over screens. It adds internal enter/back edge detection, turn tracking, a per-turn move clock with timeout, resignation and external end-of-game handling. Its state output drives the screen renderer; turn and time outputs feed the HUD and move logic.

## Interface
- CLK_FREQ_HZ, 50_000_000, clk cycles per second; prescaler period for move clock.
- SPLASH_SEC, 2, seconds the PLAYER screen is held before auto-advance to BOARD; must be ≥1.
- TURN_TIME_SEC, 60, per-move time limit in seconds; 0 disables the move clock and timeout.
- TW, $clog2(TURN_TIME_SEC+1) (min 1), derived width of time_left.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enter  in  1  active-high level, already synchronised/debounced
- back  in  1  active-high level, already synchronised/debounced
- move_done  in  1  one-cycle pulse: current player committed a legal move
- game_end  in  1  one-cycle pulse: move logic detected checkmate/stalemate
- game_end_winner  in  2  qualifies game_end: 00 white, 01 black, 10 draw
- state  out  3  0 TITLE, 1 PLAYER, 2 BOARD, 3 PLAYING, 4 GAME_OVER
- state_entry  out  1  high for the first cycle spent in a new state
- turn  out  1  0 white to move, 1 black to move
- winner  out  2  00 white, 01 black, 10 draw, 11 none
- end_reason  out  2  00 none, 01 external (game_end), 10 resign, 11 timeout
- time_left  out  TW  whole seconds remaining for current move

## Operation
- Edge detect: enter_q/back_q registers; edge = level & ~q. Both registers reset to 1, so a key held through reset yields no edge.
- TITLE: enter edge → PLAYER. back ignored.
- PLAYER: splash counter counts cycles from 0; at count == CLK_FREQ_HZ*SPLASH_SEC−1 → BOARD. back edge → TITLE (higher priority). enter ignored.
- BOARD: enter edge → PLAYING; back edge → TITLE; both same cycle → TITLE.
- PLAYING entry: turn←0, time_left←TURN_TIME_SEC, prescaler←0, winner←11, end_reason←00.
- PLAYING per-cycle priority (highest first):
  - game_end → GAME_OVER, winner←game_end_winner (11 treated as 10), end_reason←01.
  - back edge (resign) → GAME_OVER, winner←~turn, end_reason←10.
  - timeout → GAME_OVER, winner←~turn, end_reason←11.
  - move_done → turn toggles, time_left←TURN_TIME_SEC, prescaler←0.
  - enter ignored.
- Move clock, TURN_TIME_SEC>0:
  - prescaler counts 0..CLK_FREQ_HZ−1 in PLAYING and wraps.
  - On wrap with time_left>1, time_left decrements.
  - On wrap with time_left==1, timeout fires and time_left←0.
- Move clock, TURN_TIME_SEC==0: time_left held 0; timeout never fires.
- move_done on the same cycle as a timeout wrap: timeout wins. A move committed on the final cycle is late.
- GAME_OVER: winner, end_reason, turn and time_left frozen. enter edge → TITLE, which clears winner←11, end_reason←00, turn←0, time_left←0. back ignored.
- move_done/game_end outside PLAYING: ignored.
- Splash counter and prescaler held at 0 outside their states.
- Undefined state encodings 5–7 → TITLE on the next cycle.

## Timing
- All outputs registered. State changes on the clk edge after the cycle in which the causing input is sampled high.
- Input-to-state latency: 1 cycle for pulses and for the edge-detected rising level (edge computed combinationally from current input and q).
- state_entry asserts the same cycle state takes its new value, for exactly 1 cycle. It is low out of reset.
- PLAYER occupancy: exactly CLK_FREQ_HZ*SPLASH_SEC cycles.
- Move-clock timing:
  - time_left first decrements CLK_FREQ_HZ cycles after PLAYING entry or the last move_done.
  - Timeout occurs TURN_TIME_SEC*CLK_FREQ_HZ cycles after reload; GAME_OVER appears one cycle later.
- Reset values: state=0, state_entry=0, turn=0, winner=11, end_reason=00, time_left=0, all counters 0.
- reset_n low at any time, mid-splash or mid-turn: immediate asynchronous return to reset values.

## Test plan
All scenarios use CLK_FREQ_HZ=10, SPLASH_SEC=2, TURN_TIME_SEC=3.
- Reset with enter held high, release reset → state stays 0; drop then raise enter → state=1 one cycle later, state_entry=1 for one cycle.
- In PLAYER → state=2 after exactly 20 cycles; enter held high continuously from TITLE does not advance BOARD; a new edge → state=3, turn=0, time_left=3.
- PLAYING, no moves → time_left 3→2→1 at 10-cycle intervals, state=4 at cycle 31, winner=01, end_reason=11; move_done coincident with the final wrap still times out.
- PLAYING, move_done at cycle 15 → turn=1, time_left=3, next decrement 10 cycles later; back edge → state=4, winner=00, end_reason=10.
- game_end with winner 10 while turn=1 → state=4, winner=10, end_reason=01; enter edge → state=0, winner=11, end_reason=00.
- TURN_TIME_SEC=0 build: 1000 cycles in PLAYING → time_left=0, state=3; reset_n pulse mid-turn → all reset values immediately.
